// File: rtl/counter_bank.sv
// Bank of CHANNELS up/down counters with per-channel limit, load, wrap/saturate, terminal-count pulse and sticky overflow.
// Requests sampled on posedge show on q/tc/ovf one cycle later; no backpressure, every request is taken on its edge.
module counter_bank #(
  parameter int               WIDTH    = 32,
  parameter int               CHANNELS = 4,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] PRESET   = '0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          load_val,
  input  logic [CHANNELS*WIDTH-1:0] limit,
  input  logic [CHANNELS-1:0]       clr_flags,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d, lim;
  logic [CHANNELS-1:0]            tc_q, tc_d, ovf_q, ovf_d, evt;

  assign lim = limit;

  always_comb begin
    cnt_d = cnt_q;
    evt   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load[i]) begin
        cnt_d[i] = (load_val > lim[i]) ? lim[i] : load_val;
      end else if (inc[i] && !dec[i]) begin
        // >= rather than == so a counter stranded above a lowered limit still terminates
        if (cnt_q[i] >= lim[i]) begin
          evt[i]   = 1'b1;
          cnt_d[i] = SATURATE ? lim[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) begin
          evt[i]   = 1'b1;
          cnt_d[i] = SATURATE ? '0 : lim[i];
        end else begin
          cnt_d[i] = cnt_q[i] - ONE;
        end
      end
    end
    tc_d  = evt;
    // a new event outranks a clear on the same edge
    ovf_d = (ovf_q & ~clr_flags) | evt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= {CHANNELS{PRESET}};
      tc_q  <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
